gam_sample_feeder: RTL and testbench
====================================

GAM_SAMPLE_FEEDER -- requirements
Module: gam_sample_feeder

Interface
REQ-001 Parameter DATA_W, default 16, width of one input sample word X.
REQ-002 Parameter CLASS_W, default 4, width of class label C.
REQ-003 Parameter DEPTH, default 8, FIFO entries (power of 2, >=2).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-low; sampled on rising clk.
REQ-006 in_valid / in_ready  in / out  1 / 1  sample write handshake.
REQ-007 in_data / in_class  in  DATA_W / CLASS_W  sample word / label.
REQ-008 in_last  in  1  marks final sample of the learning epoch.
REQ-009 mode_recall  in  1  host request: 1 = recall mode, 0 = learning.
REQ-010 ready_wait  in  READY_WAIT_T  from memory-layer controller; READY = sample request.
REQ-011 x_out / c_out  out  DATA_W / CLASS_W  sample presented to memory layer.
REQ-012 learning_recall  out  LEARNING_RECALL_T  mode/pause to controller.
REQ-013 learning_done  out  1  epoch complete.
REQ-014 underrun  out  1  sticky: READY seen with no sample held.

Function
REQ-015 Write: entry stored when in_valid && in_ready; in_ready = !full && state!=DONE.
REQ-016 Each entry stores {in_last, in_class, in_data}; pointers log2(DEPTH)+1 bits, wrap modulo 2*DEPTH; full/empty by MSB compare.
REQ-017 Simultaneous write and pop when full: write refused (in_ready=0); when empty: pop does not see same-cycle write.
REQ-018 States: IDLE, FEED, DONE, RECALL.
REQ-019 IDLE: mode_recall=1 -> RECALL; else if !empty -> FEED; else stay.
REQ-020 FEED: on ready_wait==READY with !empty, pop head; x_out/c_out load head at that edge, hold until next pop (1-cycle latency to controller's new_input state).
REQ-021 FEED: if popped entry has in_last=1 -> DONE next cycle.
REQ-022 learning_recall = RECALL in RECALL state, and in FEED/IDLE whenever FIFO empty (pause keeps controller idle); else LEARNING.
REQ-023 ready_wait==READY while empty: no pop, outputs hold, underrun set until reset.
REQ-024 DONE: learning_done=1, learning_recall=LEARNING, in_ready=0; leave to IDLE only on reset.
REQ-025 RECALL: stay while mode_recall=1; return to IDLE when 0; FIFO writes still accepted.
REQ-026 mode_recall changes in FEED take effect only at next IDLE.

Reset
REQ-027 While reset=0 at clk edge: state=IDLE, pointers=0, x_out=0, c_out=0, learning_done=0, underrun=0, in_ready=0, learning_recall=RECALL.
REQ-028 Reset mid-epoch discards all FIFO contents and held sample; first cycle after release in_ready=1.

Configuration
REQ-029 Macro GAM_FEEDER_COUNT_EN defined: adds output sample_cnt (16 bits), count of pops since reset, saturating at 16'hFFFF; cleared on reset.
REQ-030 Macro undefined: no sample_cnt port, no counter logic; all other behaviour identical.

Verification
REQ-031 Write 3 samples (X=10,20,30, C=1,2,3, last on third), pulse READY thrice spaced 6 cycles -> x_out/c_out 10/1, 20/2, 30/3 each one cycle after its READY; learning_done=1 one cycle after third pop.
REQ-032 Fill 8 entries with no READY -> in_ready=0; 9th in_valid held, accepted one cycle after first pop.
REQ-033 READY with empty FIFO in FEED -> underrun=1, x_out unchanged, learning_recall=RECALL.
REQ-034 mode_recall=1 in IDLE -> RECALL state, learning_recall=RECALL; drop to 0 -> IDLE then FEED with pending sample.
REQ-035 Reset=0 for one cycle after 2 of 4 samples popped -> all outputs at reset values, FIFO empty, next write/pop sequence correct from entry 0.
REQ-036 With GAM_FEEDER_COUNT_EN, 5 pops -> sample_cnt=5; reset -> 0.

Source files
------------

// File: rtl/gam_sample_feeder.sv
// Sample FIFO feeding a GAM memory layer: buffers {last, class, word} entries and hands them out on READY requests.
// Optional GAM_FEEDER_COUNT_EN adds a saturating 16-bit sample_cnt output counting pops since reset.
module gam_sample_feeder #(
    parameter int DATA_W  = 16,
    parameter int CLASS_W = 4,
    parameter int DEPTH   = 8
) (
    input  logic               clk,
    input  logic               reset,
    // in_valid/in_ready: an entry transfers on a rising clk edge where both are high; in_valid
    // may be asserted independently of in_ready, and in_ready never waits on in_valid.
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [CLASS_W-1:0] in_class,
    input  logic               in_last,
    input  logic               mode_recall,
    input  logic               ready_wait,
    output logic [DATA_W-1:0]  x_out,
    output logic [CLASS_W-1:0] c_out,
    output logic               learning_recall,
    output logic               learning_done,
    output logic               underrun,
`ifdef GAM_FEEDER_COUNT_EN
    output logic [15:0]        sample_cnt,
`endif
    output logic [1:0]         state_dbg
);

    // ready_wait: 1 = READY (sample request), 0 = WAIT. learning_recall: 1 = RECALL, 0 = LEARNING.
    localparam logic READY       = 1'b1;
    localparam logic LR_RECALL   = 1'b1;
    localparam logic LR_LEARNING = 1'b0;

    localparam int AW      = $clog2(DEPTH);
    localparam int ENTRY_W = DATA_W + CLASS_W + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FEED   = 2'd1,
        S_DONE   = 2'd2,
        S_RECALL = 2'd3
    } state_t;

    state_t             state;
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic               running;
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ENTRY_W-1:0] head;
    logic               empty;
    logic               full;
    logic               wr_en;
    logic               pop;
    logic               starve;

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head   = mem[rd_ptr[AW-1:0]];

    // running holds in_ready low for the whole reset window and releases it on the first cycle after.
    assign in_ready = running && !full && (state != S_DONE);
    assign wr_en    = in_valid && in_ready;
    assign pop      = (state == S_FEED) && (ready_wait == READY) && !empty;
    assign starve   = (state == S_FEED) && (ready_wait == READY) && empty;

    assign learning_done = (state == S_DONE);
    assign state_dbg     = state;

    always_comb begin
        learning_recall = LR_LEARNING;
        if (state == S_RECALL) begin
            learning_recall = LR_RECALL;
        end else if ((state == S_IDLE || state == S_FEED) && empty) begin
            learning_recall = LR_RECALL;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= {in_last, in_class, in_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            running  <= 1'b0;
            x_out    <= '0;
            c_out    <= '0;
            underrun <= 1'b0;
        end else begin
            running <= 1'b1;
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                x_out  <= head[DATA_W-1:0];
                c_out  <= head[DATA_W +: CLASS_W];
            end
            if (starve) begin
                underrun <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (mode_recall) begin
                        state <= S_RECALL;
                    end else if (!empty) begin
                        state <= S_FEED;
                    end
                end
                S_FEED: begin
                    // mode_recall is deliberately ignored here; it is honoured on the next IDLE visit.
                    if (pop && head[ENTRY_W-1]) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_DONE;
                end
                S_RECALL: begin
                    if (!mode_recall) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef GAM_FEEDER_COUNT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            sample_cnt <= '0;
        end else if (pop && (sample_cnt != 16'hFFFF)) begin
            sample_cnt <= sample_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gam_sample_feeder.sv
// Bench for gam_sample_feeder: directed scenarios plus a randomized run against a queue-based model.
module tb_gam_sample_feeder;

  localparam int DW    = 16;
  localparam int CW    = 4;
  localparam int DEPTH = 8;
  localparam int EW    = DW + CW + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_class = '0;
  logic          in_last = 1'b0;
  logic          mode_recall = 1'b0;
  logic          ready_wait = 1'b0;
  logic [DW-1:0] x_out;
  logic [CW-1:0] c_out;
  logic          learning_recall;
  logic          learning_done;
  logic          underrun;
  logic [1:0]    state_dbg;
`ifdef GAM_FEEDER_COUNT_EN
  logic [15:0]   sample_cnt;
`endif

  int checks = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];

  gam_sample_feeder #(.DATA_W(DW), .CLASS_W(CW), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_class(in_class),
    .in_last(in_last),
    .mode_recall(mode_recall),
    .ready_wait(ready_wait),
    .x_out(x_out),
    .c_out(c_out),
    .learning_recall(learning_recall),
    .learning_done(learning_done),
    .underrun(underrun),
`ifdef GAM_FEEDER_COUNT_EN
    .sample_cnt(sample_cnt),
`endif
    .state_dbg(state_dbg)
  );

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    in_valid = 1'b0;
    ready_wait = 1'b0;
    mode_recall = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic push(input logic [DW-1:0] d, input logic [CW-1:0] c, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data = d;
    in_class = c;
    in_last = l;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL push_wait in_ready=%0b expected=1", in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic ready_pulse();
    ready_wait = 1'b1;
    tick();
    ready_wait = 1'b0;
  endtask

  // scenarios
  task automatic test_reset();
    reset = 1'b0;
    in_valid = 1'b1;
    tick();
    tick();
    checks++;
    if ({in_ready, x_out, c_out, learning_done, underrun, learning_recall, state_dbg} !==
        {1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b1, 2'd0}) begin
      failures++;
      $display("FAIL reset_values rdy=%0b x=%0h c=%0h done=%0b und=%0b lr=%0b st=%0d expected 0/0/0/0/0/1/0",
               in_ready, x_out, c_out, learning_done, underrun, learning_recall, state_dbg);
    end
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || learning_recall !== 1'b1) begin
      failures++;
      $display("FAIL reset_release in_ready=%0b lr=%0b expected 1/1", in_ready, learning_recall);
    end
  endtask

  task automatic test_basic_epoch();
    logic [DW-1:0] xs [3];
    xs[0] = 16'd10; xs[1] = 16'd20; xs[2] = 16'd30;
    do_reset();
    push(16'd10, 4'd1, 1'b0);
    push(16'd20, 4'd2, 1'b0);
    push(16'd30, 4'd3, 1'b1);
    checks++;
    if (state_dbg !== 2'd1 || learning_recall !== 1'b0) begin
      failures++;
      $display("FAIL epoch_feed st=%0d lr=%0b expected 1/0", state_dbg, learning_recall);
    end
    for (int i = 0; i < 3; i++) begin
      ready_pulse();
      checks++;
      if (x_out !== xs[i] || c_out !== 4'(i + 1)) begin
        failures++;
        $display("FAIL epoch_pop%0d x=%0d c=%0d expected %0d/%0d", i, x_out, c_out, xs[i], i + 1);
      end
      checks++;
      if (learning_done !== (i == 2)) begin
        failures++;
        $display("FAIL epoch_done%0d done=%0b expected %0b", i, learning_done, (i == 2));
      end
      if (i < 2) repeat (5) tick();
    end
    checks++;
    if (in_ready !== 1'b0 || learning_recall !== 1'b0 || state_dbg !== 2'd2) begin
      failures++;
      $display("FAIL epoch_done_state rdy=%0b lr=%0b st=%0d expected 0/0/2", in_ready, learning_recall, state_dbg);
    end
    repeat (4) tick();
    checks++;
    if (learning_done !== 1'b1 || x_out !== 16'd30) begin
      failures++;
      $display("FAIL epoch_done_hold done=%0b x=%0d expected 1/30", learning_done, x_out);
    end
  endtask

  task automatic test_full_and_underrun();
    logic [EW-1:0] e;
    do_reset();
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      push(16'(i + 1), 4'(i), 1'b0);
      exp_q.push_back({1'b0, 4'(i), 16'(i + 1)});
    end
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_ready in_ready=%0b expected 0", in_ready);
    end
    in_valid = 1'b1;
    in_data = 16'd99;
    in_class = 4'd9;
    in_last = 1'b0;
    repeat (3) tick();
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_hold in_ready=%0b expected 0", in_ready);
    end
    ready_pulse();
    e = exp_q.pop_front();
    checks++;
    if (in_ready !== 1'b1 || x_out !== e[DW-1:0]) begin
      failures++;
      $display("FAIL full_first_pop rdy=%0b x=%0d expected 1/%0d", in_ready, x_out, e[DW-1:0]);
    end
    tick();
    in_valid = 1'b0;
    exp_q.push_back({1'b0, 4'd9, 16'd99});
    while (exp_q.size() > 0) begin
      ready_pulse();
      e = exp_q.pop_front();
      checks++;
      if (x_out !== e[DW-1:0] || c_out !== e[DW +: CW]) begin
        failures++;
        $display("FAIL drain x=%0d c=%0d expected %0d/%0d", x_out, c_out, e[DW-1:0], e[DW +: CW]);
      end
    end
    checks++;
    if (learning_recall !== 1'b1 || underrun !== 1'b0) begin
      failures++;
      $display("FAIL drained lr=%0b und=%0b expected 1/0", learning_recall, underrun);
    end
    ready_pulse();
    repeat (2) tick();
    checks++;
    if (underrun !== 1'b1 || x_out !== 16'd99 || learning_recall !== 1'b1) begin
      failures++;
      $display("FAIL underrun und=%0b x=%0d lr=%0b expected 1/99/1", underrun, x_out, learning_recall);
    end
  endtask

  task automatic test_recall();
    do_reset();
    mode_recall = 1'b1;
    tick();
    checks++;
    if (state_dbg !== 2'd3 || learning_recall !== 1'b1) begin
      failures++;
      $display("FAIL recall_enter st=%0d lr=%0b expected 3/1", state_dbg, learning_recall);
    end
    push(16'h55, 4'd5, 1'b0);
    tick();
    checks++;
    if (state_dbg !== 2'd3 || learning_recall !== 1'b1) begin
      failures++;
      $display("FAIL recall_stay st=%0d lr=%0b expected 3/1", state_dbg, learning_recall);
    end
    mode_recall = 1'b0;
    tick();
    checks++;
    if (state_dbg !== 2'd0 || learning_recall !== 1'b0) begin
      failures++;
      $display("FAIL recall_exit st=%0d lr=%0b expected 0/0", state_dbg, learning_recall);
    end
    tick();
    checks++;
    if (state_dbg !== 2'd1) begin
      failures++;
      $display("FAIL recall_feed st=%0d expected 1", state_dbg);
    end
    ready_pulse();
    checks++;
    if (x_out !== 16'h55 || c_out !== 4'd5) begin
      failures++;
      $display("FAIL recall_pop x=%0h c=%0h expected 55/5", x_out, c_out);
    end
  endtask

  task automatic test_reset_mid_epoch();
    logic [DW-1:0] d [4];
    logic [DW-1:0] n0;
    logic [DW-1:0] n1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      d[i] = 16'($urandom_range(1, 16'hFFFF));
      push(d[i], 4'(i), 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      ready_pulse();
      checks++;
      if (x_out !== d[i]) begin
        failures++;
        $display("FAIL mid_pop%0d x=%0h expected %0h", i, x_out, d[i]);
      end
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({in_ready, x_out, c_out, learning_done, underrun, learning_recall, state_dbg} !==
        {1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b1, 2'd0}) begin
      failures++;
      $display("FAIL mid_reset rdy=%0b x=%0h c=%0h done=%0b und=%0b lr=%0b st=%0d expected 0/0/0/0/0/1/0",
               in_ready, x_out, c_out, learning_done, underrun, learning_recall, state_dbg);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || learning_recall !== 1'b1) begin
      failures++;
      $display("FAIL mid_release rdy=%0b lr=%0b expected 1/1 (fifo empty)", in_ready, learning_recall);
    end
    n0 = d[2] ^ 16'h00F0;
    n1 = d[3] ^ 16'h0F00;
    push(n0, 4'd7, 1'b0);
    push(n1, 4'd8, 1'b0);
    tick();
    ready_pulse();
    checks++;
    if (x_out !== n0 || c_out !== 4'd7) begin
      failures++;
      $display("FAIL mid_restart0 x=%0h c=%0h expected %0h/7", x_out, c_out, n0);
    end
    ready_pulse();
    checks++;
    if (x_out !== n1 || c_out !== 4'd8) begin
      failures++;
      $display("FAIL mid_restart1 x=%0h c=%0h expected %0h/8", x_out, c_out, n1);
    end
  endtask

  task automatic test_random();
    logic          feeding;
    logic          exp_under;
    logic [DW-1:0] exp_x;
    logic [CW-1:0] exp_c;
    logic          acc;
    logic          pop;
    logic          feed_next;
    logic [EW-1:0] e;
    do_reset();
    exp_q.delete();
    feeding = 1'b0;
    exp_under = 1'b0;
    exp_x = '0;
    exp_c = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      // alternate fill-heavy and drain-heavy phases so both full and empty are hit
      if ((cyc / 60) % 2 == 0) begin
        in_valid = ($urandom_range(0, 3) != 0);
        ready_wait = ($urandom_range(0, 3) == 0);
      end else begin
        in_valid = ($urandom_range(0, 3) == 0);
        ready_wait = ($urandom_range(0, 3) != 0);
      end
      in_data = 16'($urandom);
      in_class = 4'($urandom);
      in_last = 1'b0;
      acc = in_valid && (exp_q.size() < DEPTH);
      pop = feeding && ready_wait && (exp_q.size() > 0);
      if (feeding && ready_wait && exp_q.size() == 0) exp_under = 1'b1;
      feed_next = feeding || (exp_q.size() > 0);
      e = {in_last, in_class, in_data};
      tick();
      if (pop) begin
        exp_x = exp_q[0][DW-1:0];
        exp_c = exp_q[0][DW +: CW];
        exp_q.delete(0);
      end
      if (acc) exp_q.push_back(e);
      feeding = feed_next;
      checks++;
      if (in_ready !== (exp_q.size() < DEPTH) || learning_recall !== (exp_q.size() == 0)) begin
        failures++;
        $display("FAIL rand_flags cyc=%0d rdy=%0b lr=%0b expected %0b/%0b", cyc, in_ready, learning_recall,
                 (exp_q.size() < DEPTH), (exp_q.size() == 0));
      end
      checks++;
      if (x_out !== exp_x || c_out !== exp_c || underrun !== exp_under) begin
        failures++;
        $display("FAIL rand_data cyc=%0d x=%0h c=%0h und=%0b expected %0h/%0h/%0b", cyc, x_out, c_out,
                 underrun, exp_x, exp_c, exp_under);
      end
    end
    in_valid = 1'b0;
    ready_wait = 1'b0;
  endtask

`ifdef GAM_FEEDER_COUNT_EN
  task automatic test_count();
    do_reset();
    for (int i = 0; i < 5; i++) push(16'(i), 4'(i), 1'b0);
    for (int i = 0; i < 5; i++) ready_pulse();
    tick();
    checks++;
    if (sample_cnt !== 16'd5) begin
      failures++;
      $display("FAIL count_five sample_cnt=%0d expected 5", sample_cnt);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (sample_cnt !== 16'd0) begin
      failures++;
      $display("FAIL count_reset sample_cnt=%0d expected 0", sample_cnt);
    end
    reset = 1'b1;
    tick();
  endtask
`endif

  // sequence and final report
  initial begin
    test_reset();
    test_basic_epoch();
    test_full_and_underrun();
    test_recall();
    test_reset_mid_epoch();
    test_random();
`ifdef GAM_FEEDER_COUNT_EN
    test_count();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
